// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready handshake and tag sideband.
// Define SHIFTER_ROTATE_EN to build the rotate path; otherwise op 11 behaves as SRL.
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int PIPE  = 0,
   parameter int TAGW  = 4,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_op,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);
   localparam int LAST = SHW - 1;

   logic stall;
   logic accept;

   // Inputs to each level (index 0 = largest shift) and each level's result
   logic [WIDTH-1:0] lvl_data  [0:LAST];
   logic [SHW-1:0]   lvl_shamt [0:LAST];
   logic [1:0]       lvl_op    [0:LAST];
   logic             lvl_fill  [0:LAST];
   logic [TAGW-1:0]  lvl_tag   [0:LAST];
   logic             lvl_valid [0:LAST];
   logic [WIDTH-1:0] shift_d   [0:LAST];

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [TAGW-1:0]  out_tag_q;

   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && !stall;

   assign lvl_data[0]  = in_data;
   assign lvl_shamt[0] = in_shamt;
   assign lvl_op[0]    = in_op;
   assign lvl_fill[0]  = in_data[WIDTH-1];
   assign lvl_tag[0]   = in_tag;
   assign lvl_valid[0] = accept;

   function automatic logic [WIDTH-1:0] level_shift(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input logic             fill,
      input int               amt
   );
      logic [WIDTH-1:0] fill_mask;
      fill_mask = ~({WIDTH{1'b1}} >> amt);
      case (op)
         2'b00:   level_shift = d << amt;
         2'b10:   level_shift = (d >> amt) | (fill ? fill_mask : '0);
`ifdef SHIFTER_ROTATE_EN
         2'b11:   level_shift = (d >> amt) | (d << (WIDTH - amt));
`endif
         default: level_shift = d >> amt;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < SHW; gi++) begin : g_level
         localparam int K = SHW - 1 - gi;
         assign shift_d[gi] = lvl_shamt[gi][K]
                            ? level_shift(lvl_data[gi], lvl_op[gi], lvl_fill[gi], 1 << K)
                            : lvl_data[gi];
      end

      if (PIPE != 0) begin : g_pipe
         logic [WIDTH-1:0] data_q  [1:LAST];
         logic [SHW-1:0]   shamt_q [1:LAST];
         logic [1:0]       op_q    [1:LAST];
         logic             fill_q  [1:LAST];
         logic [TAGW-1:0]  tag_q   [1:LAST];
         logic             valid_q [1:LAST];

         // Global stall: every stage holds together, bubbles included
         always_ff @(posedge clock) begin
            if (reset) begin
               for (int s = 1; s <= LAST; s++) begin
                  data_q[s]  <= '0;
                  shamt_q[s] <= '0;
                  op_q[s]    <= '0;
                  fill_q[s]  <= 1'b0;
                  tag_q[s]   <= '0;
                  valid_q[s] <= 1'b0;
               end
            end else if (!stall) begin
               for (int s = 1; s <= LAST; s++) begin
                  data_q[s]  <= shift_d[s-1];
                  shamt_q[s] <= lvl_shamt[s-1];
                  op_q[s]    <= lvl_op[s-1];
                  fill_q[s]  <= lvl_fill[s-1];
                  tag_q[s]   <= lvl_tag[s-1];
                  valid_q[s] <= lvl_valid[s-1];
               end
            end
         end

         for (gi = 1; gi <= LAST; gi++) begin : g_stage
            assign lvl_data[gi]  = data_q[gi];
            assign lvl_shamt[gi] = shamt_q[gi];
            assign lvl_op[gi]    = op_q[gi];
            assign lvl_fill[gi]  = fill_q[gi];
            assign lvl_tag[gi]   = tag_q[gi];
            assign lvl_valid[gi] = valid_q[gi];
         end
      end else begin : g_comb
         for (gi = 1; gi <= LAST; gi++) begin : g_stage
            assign lvl_data[gi]  = shift_d[gi-1];
            assign lvl_shamt[gi] = lvl_shamt[gi-1];
            assign lvl_op[gi]    = lvl_op[gi-1];
            assign lvl_fill[gi]  = lvl_fill[gi-1];
            assign lvl_tag[gi]   = lvl_tag[gi-1];
            assign lvl_valid[gi] = lvl_valid[gi-1];
         end
      end
   endgenerate

   // Output register doubles as the last pipeline stage when PIPE=1
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
      end else if (!stall) begin
         out_valid_q <= lvl_valid[LAST];
         out_data_q  <= shift_d[LAST];
         out_tag_q   <= lvl_tag[LAST];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;

endmodule
